// File: rtl/trav_short_stack.sv
// Per-ray circular short stack for deferred far children; POP result registered one cycle after accept.
// Backpressure: a held result (out_valid & out_stall) stalls every op; oldest entry is overwritten on overflow.
module trav_short_stack #(
  parameter int NUM_RAYS = 512,
  parameter int DEPTH    = 8,
  parameter int NODE_W   = 15,
  parameter int T_W      = 32,
  parameter int ID_W     = $clog2(NUM_RAYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [1:0]        in_op,
  input  logic [ID_W-1:0]   in_rayID,
  input  logic [NODE_W-1:0] in_nodeID,
  input  logic [T_W-1:0]    in_t_max,
  output logic              in_stall,
  output logic              out_valid,
  output logic [ID_W-1:0]   out_rayID,
  output logic [NODE_W-1:0] out_nodeID,
  output logic [T_W-1:0]    out_t_max,
  output logic              out_empty,
  input  logic              out_stall
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    OP_PUSH   = 2'b00,
    OP_POP    = 2'b01,
    OP_UPDATE = 2'b10,
    OP_CLEAR  = 2'b11
  } op_e;

  logic [PW-1:0]     wptr_q   [NUM_RAYS];
  logic [CW-1:0]     num_q    [NUM_RAYS];
  logic [NODE_W-1:0] node_mem [NUM_RAYS*DEPTH];
  logic [T_W-1:0]    t_mem    [NUM_RAYS*DEPTH];

  logic              accept;
  logic [PW-1:0]     cur_wptr;
  logic [PW-1:0]     top_ptr;
  logic [CW-1:0]     cur_num;
  logic              cur_empty;
  logic [ID_W+PW-1:0] wr_addr;
  logic [ID_W+PW-1:0] top_addr;

  assign in_stall  = out_valid & out_stall;
  assign accept    = in_valid & ~in_stall;
  assign cur_wptr  = wptr_q[in_rayID];
  assign cur_num   = num_q[in_rayID];
  assign top_ptr   = cur_wptr - 1'b1;
  assign cur_empty = (cur_num == '0);
  assign wr_addr   = {in_rayID, cur_wptr};
  assign top_addr  = {in_rayID, top_ptr};

  // Pointer state lands at the accept edge so the next op on the same ray sees it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_RAYS; i++) begin
        wptr_q[i] <= '0;
        num_q[i]  <= '0;
      end
    end else if (accept) begin
      case (op_e'(in_op))
        OP_PUSH: begin
          wptr_q[in_rayID] <= cur_wptr + 1'b1;
          if (cur_num != CW'(DEPTH))
            num_q[in_rayID] <= cur_num + 1'b1;
        end
        OP_POP: begin
          if (!cur_empty) begin
            wptr_q[in_rayID] <= top_ptr;
            num_q[in_rayID]  <= cur_num - 1'b1;
          end
        end
        OP_CLEAR: begin
          wptr_q[in_rayID] <= '0;
          num_q[in_rayID]  <= '0;
        end
        default: ;
      endcase
    end
  end

  // Entry storage carries no reset; stale contents are masked by num.
  always_ff @(posedge clk) begin
    if (accept && op_e'(in_op) == OP_PUSH) begin
      node_mem[wr_addr] <= in_nodeID;
      t_mem[wr_addr]    <= in_t_max;
    end else if (accept && op_e'(in_op) == OP_UPDATE && !cur_empty) begin
      t_mem[top_addr] <= in_t_max;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_rayID  <= '0;
      out_nodeID <= '0;
      out_t_max  <= '0;
      out_empty  <= 1'b0;
    end else if (accept && op_e'(in_op) == OP_POP) begin
      out_valid  <= 1'b1;
      out_rayID  <= in_rayID;
      out_empty  <= cur_empty;
      out_nodeID <= cur_empty ? '0 : node_mem[top_addr];
      out_t_max  <= cur_empty ? '0 : t_mem[top_addr];
    end else if (out_valid && !out_stall) begin
      out_valid  <= 1'b0;
      out_rayID  <= '0;
      out_nodeID <= '0;
      out_t_max  <= '0;
      out_empty  <= 1'b0;
    end
  end

endmodule

// File: doc/trav_short_stack.md
Name: trav_short_stack

Overview:
- Per-ray short-stack unit serving the traversal unit's common push/pop/update port. It replaces the fixed `ss_wptr`/`ss_num` pair carried in `ray_info` with internally held per-ray pointers.
- Holds up to DEPTH deferred far-child entries per ray in a circular buffer. The oldest entry is overwritten on overflow (short-stack semantics).
- Returns popped entries to traversal. An empty pop tells traversal to restart from the root.

Parameters:
- NUM_RAYS, 512, number of ray slots.
- DEPTH, 8, entries per ray stack; power of two, minimum 2.
- NODE_W, 15, nodeID width.
- T_W, 32, t_max width (IEEE single bits, treated as opaque).
- ID_W, $clog2(NUM_RAYS), rayID width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_op  in  2  00 PUSH, 01 POP, 10 UPDATE, 11 CLEAR.
- in_rayID  in  ID_W  target ray.
- in_nodeID  in  NODE_W  node to push (PUSH only).
- in_t_max  in  T_W  t_max to push or update.
- in_stall  out  1  request not accepted this cycle.
- out_valid  out  1  pop result valid.
- out_rayID  out  ID_W  ray of the pop result.
- out_nodeID  out  NODE_W  popped node; 0 when empty.
- out_t_max  out  T_W  popped t_max; 0 when empty.
- out_empty  out  1  pop found an empty stack (restart from root).
- out_stall  in  1  downstream not ready.

Behaviour:
- State held:
  - Per-ray `wptr[log2 DEPTH]` points at the next free slot.
  - Per-ray `num[log2 DEPTH + 1]` counts valid entries, range 0..DEPTH.
  - Entry storage is NUM_RAYS x DEPTH x {nodeID, t_max}.
  - Storage is not reset. Only `wptr`/`num` and the output register reset.
- Reset (rst = 0, async):
  - All `wptr` = 0, all `num` = 0.
  - `out_valid` = 0; `out_rayID`, `out_nodeID`, `out_t_max`, `out_empty` = 0.
  - `in_stall` = 0 while in reset.
  - A result pending at reset is dropped.
- Handshake:
  - A request is accepted at a rising edge when `in_valid` = 1 and `in_stall` = 0.
  - `in_stall = out_valid & out_stall`. This applies to all ops and is combinational from registered state plus `out_stall`.
  - Output holds stable while `out_valid` = 1 and `out_stall` = 1.
  - The output register clears at an edge where `out_valid` = 1 and `out_stall` = 0, unless a new POP is accepted at the same edge.
- PUSH:
  - `mem[ray][wptr] <= {nodeID, t_max}`.
  - `wptr <= wptr + 1` mod DEPTH.
  - `num <= min(num + 1, DEPTH)`.
  - When `num` = DEPTH, the push overwrites the oldest entry and `num` stays DEPTH.
  - No output.
- POP, `num` > 0:
  - Result is `mem[ray][wptr - 1 mod DEPTH]`.
  - `wptr <= wptr - 1` mod DEPTH.
  - `num <= num - 1`.
  - `out_empty` = 0.
- POP, `num` = 0:
  - `out_empty` = 1, `out_nodeID` = 0, `out_t_max` = 0.
  - Pointers unchanged.
- POP latency: accepted at edge k, `out_valid` = 1 with data from edge k+1. Throughput is 1 pop per cycle when `out_stall` = 0.
- UPDATE:
  - If `num` > 0, overwrite the t_max field of the top entry (`wptr - 1`); nodeID is unchanged.
  - If `num` = 0, no-op.
  - Pointers unchanged. No output.
- CLEAR: `wptr <= 0`, `num <= 0`. Issued on ray retirement. No output.
- Back-to-back ops on the same ray see the prior op's effect; pointer and storage writes land at the accept edge. Zero bubbles required.
- Ops on different rays are fully independent.
- One request per cycle; there are no simultaneous-request cases.
- A `rayID` >= NUM_RAYS is undefined; no check is made.

Test Plan:
- Reset, then POP ray 6 -> `out_valid` next cycle, `out_empty` = 1, `out_nodeID` = 0, `out_t_max` = 0.
- PUSH ray 6 (node 12, 5.0), then (node 3, 7.0), then POP x3 back-to-back -> (3, 7.0, empty 0), (12, 5.0, empty 0), then `out_empty` = 1. Zero bubbles.
- DEPTH=8: PUSH ray 7 nodes 1..10, then POP x9:
  - Nodes 10,9,8,7,6,5,4,3 are returned.
  - The 9th pop gives `out_empty` = 1; nodes 1 and 2 are lost to wrap.
- PUSH ray 4 (node 9, 13.0), UPDATE ray 4 t_max 4.0, POP -> (9, 4.0). UPDATE on empty ray 5 -> no state change; a later POP gives `out_empty` = 1.
- Hold `out_stall` = 1 with a pop result pending -> `in_stall` = 1 and output stable. Release -> next request is accepted that edge. Randomised 50% `out_stall`: no result lost or duplicated.
- PUSH x3 to ray 2, CLEAR ray 2, POP -> `out_empty` = 1. Interleaved ray 3 entries are unaffected. Assert rst = 0 mid-stream -> `out_valid` = 0 immediately and all stacks empty.
